// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with on-demand pedestrian phase and maintenance flash.
// Define GB_EXT_EN to add the car_b input and vehicle-actuated extension of road B green.
module traffic_light_ctrl #(
  parameter int CNT_W      = 8,
  parameter int GREEN_A    = 6,
  parameter int YELLOW_A   = 4,
  parameter int GREEN_B    = 6,
  parameter int YELLOW_B   = 2,
  parameter int WALK       = 3,
  parameter int WALK_FLASH = 4,
  parameter int ALLRED     = 2,
  parameter int FLASH_HALF = 2,
  parameter int GB_EXT     = 2,
  parameter int MAX_EXT    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic       walk_req,
  input  logic       flash_mode,
`ifdef GB_EXT_EN
  input  logic       car_b,
`endif
  output logic       Ga,
  output logic       Ya,
  output logic       Ra,
  output logic       Gb,
  output logic       Yb,
  output logic       Rb,
  output logic       Gw,
  output logic       Rw,
  output logic       walk_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0, S_GA = 3'd1, S_YA = 3'd2, S_GB = 3'd3,
    S_YB = 3'd4, S_WALK = 3'd5, S_WFLASH = 3'd6, S_FLASH = 3'd7
  } state_t;

  typedef struct packed {
    logic ga, ya, ra, gb, yb, rb, gw, rw;
  } lamps_t;

  localparam int MAX_DUR = 1 << CNT_W;

  if (ALLRED < 1 || GREEN_A < 1 || YELLOW_A < 1 || GREEN_B < 1 || YELLOW_B < 1 ||
      WALK < 1 || WALK_FLASH < 1 || FLASH_HALF < 1 || GB_EXT < 1 || MAX_EXT < 0 ||
      ALLRED >= MAX_DUR || GREEN_A >= MAX_DUR || YELLOW_A >= MAX_DUR ||
      GREEN_B >= MAX_DUR || YELLOW_B >= MAX_DUR || WALK >= MAX_DUR ||
      WALK_FLASH >= MAX_DUR || FLASH_HALF >= MAX_DUR || GB_EXT >= MAX_DUR ||
      MAX_EXT >= MAX_DUR) begin : g_bad_duration
    $error("traffic_light_ctrl: phase durations must lie in [1, 2**CNT_W)");
  end

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt, w_dur_m1;
  logic             r_blink, w_nxt_blink;
  logic             r_walk_pending, w_nxt_pending;
  logic             w_term;
  lamps_t           r_lamps;
`ifdef GB_EXT_EN
  logic [CNT_W-1:0] r_ext_cnt, w_nxt_ext_cnt;
`endif

  // Blink only matters in WFLASH (don't-walk) and FLASH (all reds).
  function automatic lamps_t lamps_of(input state_t s, input logic blink);
    lamps_t l;
    l = '0;
    case (s)
      S_ALLRED: begin l.ra = 1'b1;  l.rb = 1'b1;  l.rw = 1'b1;  end
      S_GA:     begin l.ga = 1'b1;  l.rb = 1'b1;  l.rw = 1'b1;  end
      S_YA:     begin l.ya = 1'b1;  l.rb = 1'b1;  l.rw = 1'b1;  end
      S_GB:     begin l.ra = 1'b1;  l.gb = 1'b1;  l.rw = 1'b1;  end
      S_YB:     begin l.ra = 1'b1;  l.yb = 1'b1;  l.rw = 1'b1;  end
      S_WALK:   begin l.ra = 1'b1;  l.rb = 1'b1;  l.gw = 1'b1;  end
      S_WFLASH: begin l.ra = 1'b1;  l.rb = 1'b1;  l.rw = blink; end
      S_FLASH:  begin l.ra = blink; l.rb = blink; l.rw = blink; end
      default:  l = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    // NOTE: defaulting first means no path through the case leaves the signal unassigned, so no latch is inferred.
    w_dur_m1 = '0;
    case (r_state)
      S_ALLRED: w_dur_m1 = CNT_W'(ALLRED - 1);
      S_GA:     w_dur_m1 = CNT_W'(GREEN_A - 1);
      S_YA:     w_dur_m1 = CNT_W'(YELLOW_A - 1);
`ifdef GB_EXT_EN
      S_GB:     w_dur_m1 = (r_ext_cnt == '0) ? CNT_W'(GREEN_B - 1) : CNT_W'(GB_EXT - 1);
`else
      S_GB:     w_dur_m1 = CNT_W'(GREEN_B - 1);
`endif
      S_YB:     w_dur_m1 = CNT_W'(YELLOW_B - 1);
      S_WALK:   w_dur_m1 = CNT_W'(WALK - 1);
      S_WFLASH: w_dur_m1 = CNT_W'(WALK_FLASH - 1);
      S_FLASH:  w_dur_m1 = CNT_W'(FLASH_HALF - 1);
      default:  w_dur_m1 = '0;
    endcase
  end

  assign w_term = (r_cnt == w_dur_m1);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_blink   = r_blink;
    w_nxt_pending = r_walk_pending;
`ifdef GB_EXT_EN
    w_nxt_ext_cnt = r_ext_cnt;
`endif
    // Mode changes win over the timer and swallow any tick on the same cycle.
    if (flash_mode && r_state != S_FLASH) begin
      w_nxt_state = S_FLASH;
      w_nxt_cnt   = '0;
      w_nxt_blink = 1'b1;
    end else if (!flash_mode && r_state == S_FLASH) begin
      w_nxt_state = S_ALLRED;
      w_nxt_cnt   = '0;
    end else if (tick) begin
      if (!w_term) begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (r_state == S_WFLASH) w_nxt_blink = ~r_blink;
      end else begin
        w_nxt_cnt = '0;
        case (r_state)
          S_ALLRED: w_nxt_state = S_GA;
          S_GA:     w_nxt_state = S_YA;
          S_YA: begin
            w_nxt_state = S_GB;
`ifdef GB_EXT_EN
            w_nxt_ext_cnt = '0;
`endif
          end
`ifdef GB_EXT_EN
          S_GB: begin
            if (car_b && r_ext_cnt < CNT_W'(MAX_EXT)) w_nxt_ext_cnt = r_ext_cnt + 1'b1;
            else                                      w_nxt_state   = S_YB;
          end
`else
          S_GB:     w_nxt_state = S_YB;
`endif
          S_YB:     w_nxt_state = r_walk_pending ? S_WALK : S_GA;
          S_WALK: begin
            w_nxt_state = S_WFLASH;
            w_nxt_blink = 1'b1;
          end
          S_WFLASH: w_nxt_state = S_GA;
          S_FLASH:  w_nxt_blink = ~r_blink;
          default:  w_nxt_state = S_ALLRED;
        endcase
      end
    end
    if (w_nxt_state == S_WALK && r_state != S_WALK)
      w_nxt_pending = 1'b0;
    else if (walk_req && r_state != S_WALK && r_state != S_WFLASH)
      w_nxt_pending = 1'b1;
  end

  // Lamps are registered from the next state so they change on the same edge as state.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
    if (RST) begin
      r_state        <= S_ALLRED;
      r_cnt          <= '0;
      r_blink        <= 1'b1;
      r_walk_pending <= 1'b0;
      r_lamps        <= lamps_of(S_ALLRED, 1'b1);
`ifdef GB_EXT_EN
      r_ext_cnt      <= '0;
`endif
    end else begin
      r_state        <= w_nxt_state;
      r_cnt          <= w_nxt_cnt;
      r_blink        <= w_nxt_blink;
      r_walk_pending <= w_nxt_pending;
      r_lamps        <= lamps_of(w_nxt_state, w_nxt_blink);
`ifdef GB_EXT_EN
      r_ext_cnt      <= w_nxt_ext_cnt;
`endif
    end
  end

  assign Ga           = r_lamps.ga;
  assign Ya           = r_lamps.ya;
  assign Ra           = r_lamps.ra;
  assign Gb           = r_lamps.gb;
  assign Yb           = r_lamps.yb;
  assign Rb           = r_lamps.rb;
  assign Gw           = r_lamps.gw;
  assign Rw           = r_lamps.rw;
  assign walk_pending = r_walk_pending;
  assign state        = r_state;

endmodule
